// File: rtl/gc_ctrl_pkg.sv
// Shared GC-DRAM controller types: default widths and bank/read-word typedefs.
package gc_ctrl_pkg;

  localparam int NUM_BANKS_DEFAULT = 8;
  localparam int DATA_W_DEFAULT    = 64;
  localparam int DEPTH_DEFAULT     = 4;

  typedef logic [$clog2(NUM_BANKS_DEFAULT)-1:0] bank_id_t;
  typedef logic [DATA_W_DEFAULT-1:0]            rd_word_t;

endpackage

// File: rtl/gc_read_return_mux_if.sv
// Issue, bank read-return and host response signals of the read return mux.
// out_parity exists only when GC_RDMUX_PARITY_EN is defined.
interface gc_read_return_mux_if #(
  parameter int NUM_BANKS = 8,
  parameter int DATA_W    = 64,
  parameter int BANK_W    = $clog2(NUM_BANKS)
);

  logic                        issue_valid;
  logic [BANK_W-1:0]           issue_bank;
  logic                        issue_ready;
  logic [NUM_BANKS-1:0]        bank_rd_valid;
  logic [NUM_BANKS*DATA_W-1:0] bank_rd_data;
  logic                        out_valid;
  logic [DATA_W-1:0]           out_data;
  logic [BANK_W-1:0]           out_bank;
  logic                        out_ready;
  logic                        err_sticky;
`ifdef GC_RDMUX_PARITY_EN
  logic                        out_parity;

  modport master (
    output issue_valid, issue_bank, bank_rd_valid, bank_rd_data, out_ready,
    input  issue_ready, out_valid, out_data, out_bank, err_sticky, out_parity
  );
  modport slave (
    input  issue_valid, issue_bank, bank_rd_valid, bank_rd_data, out_ready,
    output issue_ready, out_valid, out_data, out_bank, err_sticky, out_parity
  );
`else
  modport master (
    output issue_valid, issue_bank, bank_rd_valid, bank_rd_data, out_ready,
    input  issue_ready, out_valid, out_data, out_bank, err_sticky
  );
  modport slave (
    input  issue_valid, issue_bank, bank_rd_valid, bank_rd_data, out_ready,
    output issue_ready, out_valid, out_data, out_bank, err_sticky
  );
`endif

endinterface

// File: rtl/gc_bank_id_fifo.sv
// In-order FIFO of issued bank IDs; pointers carry an extra wrap bit.
module gc_bank_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

endmodule

// File: rtl/gc_read_return_mux.sv
// Steers the expected bank's read word to a registered valid/ready output and
// flags out-of-order or unserviceable returns. Option: GC_RDMUX_PARITY_EN.
module gc_read_return_mux
  import gc_ctrl_pkg::*;
#(
  parameter int NUM_BANKS = NUM_BANKS_DEFAULT,
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int DEPTH     = DEPTH_DEFAULT,
  parameter int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic                    clk,
  input  logic                    rst,
  gc_read_return_mux_if.slave     bus
);

  logic [BANK_W-1:0]    head;
  logic                 fifo_full, fifo_empty;
  logic                 push, capture, head_hit, can_load, stray;
  logic [NUM_BANKS-1:0] head_mask;
  logic [DATA_W-1:0]    bank_word [NUM_BANKS];
  logic [DATA_W-1:0]    head_word;

  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [BANK_W-1:0]    out_bank_q, out_bank_d;
  logic                 err_q, err_d;

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      assign bank_word[gi] = bus.bank_rd_data[gi*DATA_W +: DATA_W];
      assign head_mask[gi] = (head == BANK_W'(gi));
    end
  endgenerate

  gc_bank_id_fifo #(.DEPTH(DEPTH), .WIDTH(BANK_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.issue_bank),
    .pop   (capture),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign push      = bus.issue_valid && !fifo_full;
  assign head_word = bank_word[head];
  assign can_load  = !out_valid_q || bus.out_ready;
  assign head_hit  = !fifo_empty && |(bus.bank_rd_valid & head_mask);
  assign capture   = head_hit && can_load;
  // With nothing outstanding every strobe is unexpected, including the stale head slot.
  assign stray     = fifo_empty ? |bus.bank_rd_valid : |(bus.bank_rd_valid & ~head_mask);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_bank_d  = out_bank_q;
    err_d       = err_q | stray | (head_hit && !can_load);
    if (capture) begin
      out_valid_d = 1'b1;
      out_data_d  = head_word;
      out_bank_d  = head;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_bank_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_bank_q  <= out_bank_d;
      err_q       <= err_d;
    end
  end

`ifdef GC_RDMUX_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = capture ? ^head_word : parity_q;

  always_ff @(posedge clk) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end

  assign bus.out_parity = parity_q;
`endif

  assign bus.issue_ready = !fifo_full;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_bank    = out_bank_q;
  assign bus.err_sticky  = err_q;

endmodule

// File: doc/gc_read_return_mux.md
# gc_read_return_mux

Parametrised read-data return selector for the GC-DRAM controller. It steers the read word from one of `NUM_BANKS` bank read ports onto a single registered output with a valid/ready handshake. An in-order queue of issued bank IDs determines which bank is expected next. The block sits between the bank array read ports and the controller's host read-response channel, and detects out-of-order or unserviceable bank returns.

## Interface

- `NUM_BANKS`, default 8: number of bank read ports (≥2).
- `DATA_W`, default 64: read word width.
- `DEPTH`, default 4: outstanding-read queue depth (power of two, ≥2).
- `BANK_W`, default `$clog2(NUM_BANKS)`: bank ID width (derived; do not override).

Ports (one clock; reset is synchronous and active-high):

- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous active-high reset.
- `issue_valid` in 1: controller issues a read to `issue_bank`.
- `issue_bank` in `BANK_W`: bank ID of the issued read.
- `issue_ready` out 1: queue not full.
- `bank_rd_valid` in `NUM_BANKS`: per-bank one-cycle read-data strobe.
- `bank_rd_data` in `NUM_BANKS`×`DATA_W`: packed per-bank read words.
- `out_valid` out 1: output word valid.
- `out_data` out `DATA_W`: selected read word.
- `out_bank` out `BANK_W`: bank the word came from.
- `out_ready` in 1: consumer accepts.
- `err_sticky` out 1: protocol error seen; cleared only by `rst`.
- `out_parity` out 1: even parity over `out_data`; present only with `GC_RDMUX_PARITY_EN`.

## Operation

- Queue: FIFO of `DEPTH` bank IDs. Push when `issue_valid && issue_ready`. `issue_ready = !full`; there is no push-on-full bypass, even with a same-cycle pop.
- `head` is the oldest queued bank ID. `can_load = !out_valid || out_ready`.
- Capture: when queue non-empty, `bank_rd_valid[head]` is set, and `can_load` holds:
  - load `out_data <= bank_rd_data[head]` and `out_bank <= head`;
  - set `out_valid`;
  - pop the queue.
- Output handshake: the word transfers when `out_valid && out_ready`. `out_valid` drops the next cycle unless a new capture happens in the same cycle. `out_data` and `out_bank` are stable while `out_valid && !out_ready`.
- Errors set `err_sticky` and drop the offending data; the queue is not popped:
  - any `bank_rd_valid[i]` with `i != head`;
  - any `bank_rd_valid` bit while the queue is empty;
  - `bank_rd_valid[head]` while `!can_load` (overflow).
- Multiple `bank_rd_valid` bits in one cycle: the head bank is still captured if legal; the others flag an error.
- Simultaneous push and pop: both take effect and occupancy is unchanged. A push into an empty queue cannot be captured in the same cycle; the earliest capture is the next cycle.
- Pointers are `$clog2(DEPTH)+1` bits with wrap bit. Full when the index bits are equal and the wrap bits differ; empty when all bits are equal.

## Timing

- Capture latency: `bank_rd_valid[head]` in cycle t gives `out_valid=1` with that data in cycle t+1.
- Sustained throughput is one word per cycle when `out_ready` is held high.
- `issue_ready` reflects occupancy registered at the previous edge.
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_bank=0`, `err_sticky=0`, `out_parity=0`;
  - queue empty, so `issue_ready=1`.
- Reset mid-operation (`rst` high at an edge) flushes the queue and output register; in-flight words are discarded.
- `err_sticky` is set in cycle t+1 for a violation in cycle t.

## Configuration

- `GC_RDMUX_PARITY_EN` defined:
  - `out_parity` is registered alongside `out_data` as the XOR reduction of the captured word;
  - same latency and stability rules as `out_data`.
- Not defined: the `out_parity` port and its logic are absent.

## Structure

- Shared package `gc_ctrl_pkg` holds the `DATA_W` default, a `bank_id_t` typedef sized from `NUM_BANKS`, and the `rd_word_t` typedef.
- One sub-module, `gc_bank_id_fifo`, is the parametrised `DEPTH`×`BANK_W` FIFO providing `push`, `pop`, `head`, `full` and `empty`.
- Top level holds the select mux, output register and error logic.

## Test plan

- Issue banks 3, 5, 0. Banks return in that order with data `0xA3`, `0xA5`, `0xA0`, `out_ready=1`. Expected: outputs in order one cycle after each strobe, `out_bank` 3/5/0, `err_sticky=0`.
- Issue 4 reads to fill `DEPTH=4`. Expected: `issue_ready=0` with a 5th `issue_valid` ignored; after one capture, `issue_ready=1` the next cycle.
- Hold `out_ready=0` with `out_valid=1`, then strobe the head bank. Expected: `err_sticky=1`, output word unchanged, queue occupancy unchanged.
- Issue bank 2 and strobe bank 6. Expected: `err_sticky=1` and no `out_valid`. A following bank 2 strobe is captured normally.
- Assert `rst` with 3 entries queued and `out_valid=1`. Expected: the next cycle shows `out_valid=0`, `issue_ready=1`, `err_sticky=0`, and the queue empty.
- With `GC_RDMUX_PARITY_EN`, capture `0x...0007` then `0x...0003`. Expected: `out_parity` is 1 then 0.
